// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, funct3 codes, state encoding and alignment helper for the load/store unit
package mem_access_pkg;
  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] ADDR_MASK = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  function automatic logic [2:0] align_bits(input logic [2:0] f3);
    return f3[1:0] == 2'd0 ? 3'b000 : f3[1:0] == 2'd1 ? 3'b001 : f3[1:0] == 2'd2 ? 3'b011 : 3'b111;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational load extract/extend and store byte-merge within one doubleword
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merge_data
);
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] d, input logic [2:0] off, input logic [2:0] f3);
    logic [XLEN-1:0] s;
    s = d >> {off, 3'b000};
    return f3[1:0] == 2'd0 ? {{56{s[7] & ~f3[2]}}, s[7:0]} :
           f3[1:0] == 2'd1 ? {{48{s[15] & ~f3[2]}}, s[15:0]} :
           f3[1:0] == 2'd2 ? {{32{s[31] & ~f3[2]}}, s[31:0]} : s;
  endfunction
  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] d, input logic [XLEN-1:0] w, input logic [2:0] off, input logic [2:0] f3);
    logic [XLEN-1:0] m;
    m = f3[1:0] == 2'd0 ? 64'hFF : f3[1:0] == 2'd1 ? 64'hFFFF : f3[1:0] == 2'd2 ? 64'hFFFF_FFFF : '1;
    m = m << {off, 3'b000};
    return (d & ~m) | ((w << {off, 3'b000}) & m);
  endfunction
  assign load_data  = extract(rdata, offset, funct3);
  assign merge_data = merge(rdata, wdata, offset, funct3);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store initiator with read-modify-write stores; MISALIGN_TRAP_EN makes misaligned accesses errors
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            resp_valid,
  output logic            resp_err,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] Mem_Addr,
  output logic [XLEN-1:0] Write_Data,
  output logic            memRead,
  output logic            memWrite,
  input  logic [XLEN-1:0] Read_Data
);
  state_t state, state_n;
  logic [XLEN-1:0] rdata_q, sdata_q, ext_data;
  logic [2:0] f3_q, off_q, off_req;
  logic load_q, err_q, hs, illegal, misalign, err_req;
  assign hs = req_valid & (state == IDLE) & (is_load | is_store);
  assign illegal = (is_load & is_store) | (funct3 == 3'b111) | (is_store & funct3[2]);
`ifdef MISALIGN_TRAP_EN
  assign misalign = |(addr[2:0] & align_bits(funct3));
  assign off_req = addr[2:0];
`else
  assign misalign = 1'b0;
  assign off_req = addr[2:0] & ~align_bits(funct3);
`endif
  assign err_req = illegal | misalign;
  always_comb begin
    state_n = state;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    memRead = 1'b0;
    memWrite = 1'b0;
    state_n = state == IDLE ? (hs ? (err_req ? RESP : RD) : IDLE) :
              state == RD   ? (load_q ? RESP : WR) :
              state == WR   ? RESP : IDLE;
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    memRead = state == RD;
    memWrite = state == WR;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      rdata_q <= '0;
      sdata_q <= '0;
      f3_q <= '0;
      off_q <= '0;
      load_q <= 1'b0;
      err_q <= 1'b0;
      Mem_Addr <= '0;
    end else begin
      state <= state_n;
      if (hs) begin
        f3_q <= funct3;
        off_q <= off_req;
        sdata_q <= store_data;
        load_q <= is_load & ~is_store;
        err_q <= err_req;
        if (!err_req) Mem_Addr <= addr & ADDR_MASK;
      end
      if (state == RD) rdata_q <= Read_Data;
    end
  end
  mem_lane_align u_align (
    .rdata(rdata_q),
    .wdata(sdata_q),
    .offset(off_q),
    .funct3(f3_q),
    .load_data(ext_data),
    .merge_data(Write_Data)
  );
  assign resp_err = resp_valid & err_q;
  assign load_data = (resp_valid & load_q & ~err_q) ? ext_data : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against a byte-level memory model
module tb_mem_access_unit;
  logic clock = 1'b0, reset = 1'b1, req_valid = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [2:0] funct3 = '0;
  logic [63:0] addr = '0, store_data = '0;
  logic req_ready, resp_valid, resp_err, memRead, memWrite;
  logic [63:0] load_data, Mem_Addr, Write_Data, Read_Data;
  logic [63:0] mem [16];
  logic [63:0] ref_mem [16];
  int n_vec = 0, n_bad = 0;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  mem_access_unit dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .resp_valid(resp_valid), .resp_err(resp_err),
    .load_data(load_data), .Mem_Addr(Mem_Addr), .Write_Data(Write_Data),
    .memRead(memRead), .memWrite(memWrite), .Read_Data(Read_Data)
  );
  always #5 clock = ~clock;
  assign Read_Data = mem[Mem_Addr[6:3]];
  always @(posedge clock) if (memWrite) mem[Mem_Addr[6:3]] <= Write_Data;
  function automatic int width_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction
  function automatic int eff_off(input logic [2:0] f3, input logic [63:0] a);
    int o = int'(a[2:0]);
    return TRAP ? o : o - (o % width_of(f3));
  endfunction
  function automatic logic model_err(input logic ld, input logic st, input logic [2:0] f3, input logic [63:0] a);
    if (ld && st) return 1'b1;
    if (f3 == 3'd7) return 1'b1;
    if (st && f3 >= 3'd4) return 1'b1;
    if (TRAP && (int'(a[2:0]) % width_of(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a);
    logic [63:0] v = '0;
    logic [63:0] dw = ref_mem[a[6:3]];
    int w = width_of(f3);
    int o = eff_off(f3, a);
    for (int i = 0; i < w; i++) v = v | (64'(dw[8*(o+i) +: 8]) << (8*i));
    if (!f3[2] && w < 8 && v[8*w-1]) v = v | ({64{1'b1}} << (8*w));
    return v;
  endfunction
  task automatic model_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
    int w = width_of(f3);
    int o = eff_off(f3, a);
    for (int i = 0; i < w; i++) ref_mem[a[6:3]][8*(o+i) +: 8] = d[8*i +: 8];
  endtask
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d,
                       output logic [63:0] got, output logic err, output int lat, output int rd_cnt, output int wr_cnt,
                       output logic overlap, output logic [63:0] wd, output logic [63:0] ma);
    int w = 0;
    while (!req_ready && w < 20) begin @(negedge clock); w++; end
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = d;
    @(posedge clock);
    #1 req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    got = '0; err = 1'b0; lat = 99; rd_cnt = 0; wr_cnt = 0; overlap = 1'b0; wd = '0; ma = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (memRead) begin rd_cnt++; ma = Mem_Addr; end
      if (memWrite) begin wr_cnt++; wd = Write_Data; end
      if (memRead && memWrite) overlap = 1'b1;
      if (resp_valid) begin lat = k; got = load_data; err = resp_err; break; end
    end
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_vec++; if ({req_ready, resp_valid, resp_err, memRead, memWrite} !== 5'b10000) begin n_bad++; $display("FAIL reset_ctrl got=%b want=10000", {req_ready, resp_valid, resp_err, memRead, memWrite}); end
    n_vec++; if ({load_data, Mem_Addr, Write_Data} !== '0) begin n_bad++; $display("FAIL reset_data ld=%h ma=%h wd=%h want 0", load_data, Mem_Addr, Write_Data); end
    reset = 1'b0;
    @(negedge clock);
    n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_idle ready=%b resp=%b want 1/0", req_ready, resp_valid); end
  endtask
  task automatic test_loads;
    logic [63:0] got, wd, ma; logic err, ov; int lat, rc, wc;
    logic [2:0] f3s [3] = '{3'b000, 3'b000, 3'b100};
    logic [63:0] as [3] = '{64'h13, 64'h17, 64'h17};
    logic [63:0] ex [3] = '{64'h44, 64'hFFFF_FFFF_FFFF_FF88, 64'h88};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b0, f3s[i], as[i], '0, got, err, lat, rc, wc, ov, wd, ma);
      n_vec++; if (got !== ex[i] || err !== 1'b0) begin n_bad++; $display("FAIL load_%0d got=%h err=%b want=%h err=0", i, got, err, ex[i]); end
      n_vec++; if (lat != 2) begin n_bad++; $display("FAIL load_lat_%0d got=%0d want=2", i, lat); end
      n_vec++; if (ma !== 64'h10 || rc != 1) begin n_bad++; $display("FAIL load_addr_%0d got=%h reads=%0d want=10 reads=1", i, ma, rc); end
    end
  endtask
  task automatic test_store_merge;
    logic [63:0] got, wd, ma; logic err, ov; int lat, rc, wc;
    issue(1'b0, 1'b1, 3'b001, 64'h12, 64'hBEEF, got, err, lat, rc, wc, ov, wd, ma);
    model_store(3'b001, 64'h12, 64'hBEEF);
    n_vec++; if (wc != 1 || wd !== 64'h8877_6655_BEEF_2211) begin n_bad++; $display("FAIL sh_write pulses=%0d wd=%h want 1 88776655beef2211", wc, wd); end
    n_vec++; if (lat != 3 || err !== 1'b0 || got !== '0) begin n_bad++; $display("FAIL sh_resp lat=%0d err=%b ld=%h want 3 0 0", lat, err, got); end
    n_vec++; if (ov !== 1'b0) begin n_bad++; $display("FAIL sh_overlap got=%b want 0", ov); end
    issue(1'b1, 1'b0, 3'b011, 64'h10, '0, got, err, lat, rc, wc, ov, wd, ma);
    n_vec++; if (got !== 64'h8877_6655_BEEF_2211) begin n_bad++; $display("FAIL ld_after_sh got=%h want 88776655beef2211", got); end
  endtask
  task automatic test_sd_lw;
    logic [63:0] got, wd, ma; logic err, ov; int lat, rc, wc;
    issue(1'b0, 1'b1, 3'b011, 64'h18, 64'hDEAD_BEEF_0123_4567, got, err, lat, rc, wc, ov, wd, ma);
    model_store(3'b011, 64'h18, 64'hDEAD_BEEF_0123_4567);
    n_vec++; if (lat != 3 || rc != 1 || wc != 1) begin n_bad++; $display("FAIL sd_seq lat=%0d rd=%0d wr=%0d want 3 1 1", lat, rc, wc); end
    issue(1'b1, 1'b0, 3'b010, 64'h1C, '0, got, err, lat, rc, wc, ov, wd, ma);
    n_vec++; if (got !== 64'hFFFF_FFFF_DEAD_BEEF) begin n_bad++; $display("FAIL lw_1c got=%h want ffffffffdeadbeef", got); end
    issue(1'b1, 1'b0, 3'b110, 64'h1C, '0, got, err, lat, rc, wc, ov, wd, ma);
    n_vec++; if (got !== 64'hDEAD_BEEF) begin n_bad++; $display("FAIL lwu_1c got=%h want deadbeef", got); end
  endtask
  task automatic test_errors;
    logic [63:0] got, wd, ma, exp; logic err, ov; int lat, rc, wc;
    issue(1'b1, 1'b1, 3'b011, 64'h10, '0, got, err, lat, rc, wc, ov, wd, ma);
    n_vec++; if (err !== 1'b1 || lat != 1 || got !== '0) begin n_bad++; $display("FAIL both_err err=%b lat=%0d ld=%h want 1 1 0", err, lat, got); end
    n_vec++; if (rc != 0 || wc != 0) begin n_bad++; $display("FAIL both_nomem rd=%0d wr=%0d want 0 0", rc, wc); end
    issue(1'b1, 1'b0, 3'b111, 64'h10, '0, got, err, lat, rc, wc, ov, wd, ma);
    n_vec++; if (err !== 1'b1 || lat != 1 || rc != 0) begin n_bad++; $display("FAIL f3_111 err=%b lat=%0d rd=%0d want 1 1 0", err, lat, rc); end
    issue(1'b0, 1'b1, 3'b100, 64'h10, 64'h55, got, err, lat, rc, wc, ov, wd, ma);
    n_vec++; if (err !== 1'b1 || wc != 0) begin n_bad++; $display("FAIL store_bu err=%b wr=%0d want 1 0", err, wc); end
    issue(1'b1, 1'b0, 3'b010, 64'h12, '0, got, err, lat, rc, wc, ov, wd, ma);
    exp = TRAP ? 64'h0 : 64'hFFFF_FFFF_BEEF_2211;
    n_vec++; if (err !== TRAP || got !== exp || lat != (TRAP ? 1 : 2)) begin n_bad++; $display("FAIL lw_misalign err=%b ld=%h lat=%0d want %b %h", err, got, lat, TRAP, exp); end
  endtask
  task automatic test_back_to_back;
    int hs_c[$], resp_c[$];
    logic ovl = 1'b0, data_ok = 1'b1;
    while (!req_ready) @(negedge clock);
    req_valid = 1'b1; is_load = 1'b1; funct3 = 3'b011; addr = 64'h10;
    for (int c = 0; c < 12; c++) begin
      if (req_ready) hs_c.push_back(c);
      if (resp_valid) begin resp_c.push_back(c); if (load_data !== model_load(3'b011, 64'h10)) data_ok = 1'b0; end
      if (memRead && memWrite) ovl = 1'b1;
      @(negedge clock);
    end
    req_valid = 1'b0; is_load = 1'b0;
    n_vec++; if (hs_c.size() != 4 || resp_c.size() != 4) begin n_bad++; $display("FAIL b2b_counts hs=%0d resp=%0d want 4 4", hs_c.size(), resp_c.size()); end
    else begin
      n_vec++; if (resp_c[0] != 2 || hs_c[1] != resp_c[0] + 1) begin n_bad++; $display("FAIL b2b_order resp0=%0d hs1=%0d want 2 3", resp_c[0], hs_c[1]); end
    end
    n_vec++; if (ovl !== 1'b0 || data_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_misc overlap=%b data_ok=%b want 0 1", ovl, data_ok); end
  endtask
  task automatic test_reset_in_rd;
    int wc = 0, rv = 0;
    logic rdy;
    while (!req_ready) @(negedge clock);
    req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 64'h15; store_data = 64'hAA;
    @(posedge clock);
    #1 req_valid = 1'b0; is_store = 1'b0; reset = 1'b1;
    n_vec++; if (memRead !== 1'b1) begin n_bad++; $display("FAIL rst_rd_state memRead=%b want 1", memRead); end
    @(posedge clock);
    #1 reset = 1'b0;
    rdy = req_ready;
    for (int k = 0; k < 5; k++) begin @(negedge clock); if (memWrite) wc++; if (resp_valid) rv++; end
    n_vec++; if (wc != 0 || rv != 0 || rdy !== 1'b1) begin n_bad++; $display("FAIL rst_rd writes=%0d resps=%0d ready=%b want 0 0 1", wc, rv, rdy); end
    n_vec++; if (mem[2] !== ref_mem[2]) begin n_bad++; $display("FAIL rst_rd_mem got=%h want %h", mem[2], ref_mem[2]); end
  endtask
  task automatic test_random;
    logic [63:0] got, wd, ma, a, d, exp; logic err, ov, ld, st, e; int lat, rc, wc, r; logic [2:0] f3;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      ld = (r < 5) || (r == 9); st = (r >= 5);
      f3 = 3'($urandom_range(0, 7));
      a = 64'($urandom_range(0, 127));
      d = {$urandom, $urandom};
      e = model_err(ld, st, f3, a);
      issue(ld, st, f3, a, d, got, err, lat, rc, wc, ov, wd, ma);
      n_vec++; if (err !== e) begin n_bad++; $display("FAIL rnd_err_%0d ld=%b st=%b f3=%0d a=%h got=%b want=%b", n, ld, st, f3, a, err, e); end
      if (!e && st) model_store(f3, a, d);
      exp = (!e && ld) ? model_load(f3, a) : 64'h0;
      n_vec++; if (got !== exp) begin n_bad++; $display("FAIL rnd_data_%0d f3=%0d a=%h got=%h want=%h", n, f3, a, got, exp); end
      n_vec++; if (lat != (e ? 1 : st ? 3 : 2) || wc != ((!e && st) ? 1 : 0) || ov !== 1'b0) begin n_bad++; $display("FAIL rnd_seq_%0d lat=%0d wr=%0d ov=%b", n, lat, wc, ov); end
      if (!e) begin
        n_vec++; if (ma !== (a & 64'hFFFF_FFFF_FFFF_FFF8)) begin n_bad++; $display("FAIL rnd_addr_%0d got=%h want=%h", n, ma, a & 64'hFFFF_FFFF_FFFF_FFF8); end
      end
    end
    @(negedge clock);
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (mem[i] !== ref_mem[i]) begin n_bad++; $display("FAIL mem_%0d got=%h want=%h", i, mem[i], ref_mem[i]); end
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = {$urandom, $urandom}; ref_mem[i] = mem[i]; end
    mem[2] = 64'h8877_6655_4433_2211;
    ref_mem[2] = mem[2];
    test_reset;
    test_loads;
    test_store_merge;
    test_sd_lw;
    test_errors;
    test_back_to_back;
    test_reset_in_rd;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
